// File: rtl/mod5_pkg.sv
// Shared types and residue arithmetic for the divisible-by-5 serial transmitter.
// MOD5_TX_CHECK_ERR_EN (optional define) enables the output self-check in mod5_check_tx.
package mod5_pkg;

  localparam int MOD5_CHECK_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } mod5_tx_state_t;

  // One step of the running residue: (2r + b) mod 5, with r already in 0..4.
  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

  // Check field c = 2r mod 5, so that (word * 8 + c) is a multiple of 5.
  function automatic logic [2:0] mod5_check(input logic [2:0] r);
    logic [2:0] c;
    case (r)
      3'd0:    c = 3'd0;
      3'd1:    c = 3'd2;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd1;
      3'd4:    c = 3'd3;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod5_stream_monitor.sv
// Shadow divisible-by-5 tracker over a serial stream; err is sticky once a frame
// ends (last=1) with a non-zero residue. Cleared only by reset.
module mod5_stream_monitor
  import mod5_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_bit,
  input  logic last,
  output logic err
);

  logic [2:0] s;
  logic [2:0] s_next;
  logic       err_q;
  logic       fault_now;

  assign s_next    = mod5_step(s, data_bit);
  assign fault_now = !reset && last && (s_next != 3'd0);
  // Flag already in the offending last-bit cycle, then hold it.
  assign err       = err_q | fault_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      s     <= 3'd0;
      err_q <= 1'b0;
    end else begin
      s <= s_next;
      if (fault_now) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/mod5_check_tx.sv
// Word-to-serial transmitter: payload MSB-first followed by a 3-bit check field that
// makes each frame a multiple of 5. MOD5_TX_CHECK_ERR_EN adds the chk_err self-check.
//
// Handshake: a word is taken on a rising edge where din_valid && din_ready; din_ready is
// combinational, low in reset and in DATA, high in IDLE and while the last check bit is out.
module mod5_check_tx
  import mod5_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  output mod5_tx_state_t        dbg_state
`ifdef MOD5_TX_CHECK_ERR_EN
  ,
  output logic                  chk_err
`endif
);

  localparam int FRAME_LEN = DATA_WIDTH + MOD5_CHECK_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(FRAME_LEN - 2);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

  mod5_tx_state_t        state;
  logic [DATA_WIDTH-1:0] word;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            res;
  logic [2:0]            chk;
  logic [2:0]            chk_val;
  logic                  accept;

  // cnt is the index within the frame of the bit currently on dout.
  assign din_ready = !reset && ((state == IDLE) || ((state == CHECK) && (cnt == LAST_BIT)));
  assign accept    = din_valid && din_ready;
  assign chk_val   = mod5_check(res);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      cnt        <= '0;
      res        <= 3'd0;
      chk        <= 3'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (accept) begin
      // MSB goes out right away; residue restarts from this bit alone.
      state      <= DATA;
      word       <= din << 1;
      cnt        <= '0;
      res        <= mod5_step(3'd0, din[DATA_WIDTH-1]);
      chk        <= 3'd0;
      dout       <= din[DATA_WIDTH-1];
      dout_valid <= 1'b1;
      dout_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end
        DATA: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_DATA) begin
            state     <= CHECK;
            dout      <= chk_val[2];
            chk       <= {chk_val[1:0], 1'b0};
            dout_last <= 1'b0;
          end else begin
            word <= word << 1;
            res  <= mod5_step(res, word[DATA_WIDTH-1]);
            dout <= word[DATA_WIDTH-1];
          end
        end
        CHECK: begin
          if (cnt == LAST_BIT) begin
            state      <= IDLE;
            cnt        <= '0;
            res        <= 3'd0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            dout      <= chk[2];
            chk       <= {chk[1:0], 1'b0};
            dout_last <= (cnt == PRE_LAST);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD5_TX_CHECK_ERR_EN
  mod5_stream_monitor u_monitor (
    .clk      (clk),
    .reset    (reset),
    .data_bit (dout),
    .last     (dout_last),
    .err      (chk_err)
  );
`endif

endmodule
